bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 12, word address width.
- DATA_W, 32, data width.
- STRB_W, DATA_W/8, byte write-enable width.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  sole clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- rN_req_valid  in  1  request N valid (N = 0, 1).
- rN_req_ready  out  1  request N accepted this cycle.
- rN_req_we  in  STRB_W  byte write enables; all-zero means read.
- rN_req_addr  in  ADDR_W  word address.
- rN_req_wdata  in  DATA_W  write data.
- rN_rsp_valid  out  1  read data for requester N valid.
- rN_rsp_rdata  out  DATA_W  read data.
- bram_en  out  1  BRAM port enable.
- bram_we  out  STRB_W  BRAM byte write enables.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wrdata  out  DATA_W  BRAM write data.
- bram_rddata  in  DATA_W  BRAM read data; 1-cycle latency after bram_en.

Function
REQ-003 Handshake: a request SHALL transfer when rN_req_valid && rN_req_ready in cycle T.
REQ-004 Ready: at most one rN_req_ready SHALL be high per cycle; ready SHALL be asserted only to a requester whose valid is high.
REQ-005 Ready timing: ready SHALL depend combinationally on the valids and the priority pointer only.
REQ-006 Single requester: when only one valid is high, that requester SHALL be granted in the same cycle.
REQ-007 Conflict: when both valids are high, the requester indicated by the priority pointer SHALL win.
REQ-008 Priority pointer: after any transfer, the pointer SHALL point to the non-granted requester.
REQ-009 Bounded wait: a requester holding valid SHALL wait at most 1 cycle for a grant.
REQ-010 Issue stage: bram_en, bram_we, bram_addr and bram_wrdata SHALL be registered and driven in cycle T+1 from the granted request.
REQ-011 Idle outputs: with no transfer in T, bram_en and bram_we SHALL be 0 in T+1; addr and wrdata SHALL hold their previous values.
REQ-012 Read response: a read (we == 0) transferred in T SHALL raise rN_rsp_valid for the granted requester only, for exactly one cycle, in T+2.
REQ-013 Read data: in T+2, rN_rsp_rdata SHALL equal bram_rddata.
REQ-014 Writes: writes SHALL produce no response.
REQ-015 Inactive response data: rN_rsp_rdata SHALL be 0 whenever rN_rsp_valid is 0.
REQ-016 Throughput: one transfer per cycle SHALL be sustained; back-to-back reads SHALL give back-to-back responses in order.
REQ-017 Ordering: a write at T followed by a read to the same address at T+1 SHALL return the written data.
REQ-018 Pipeline state: the response pipeline SHALL carry a valid bit and a requester-ID bit.
REQ-019 Pipeline sizing: the pipeline SHALL have no backpressure and never stall.

Reset
REQ-020 While reset is high, all of the following SHALL be 0, with the priority pointer selecting r0:
- all ready, rsp_valid and rsp_rdata outputs;
- bram_en, bram_we, bram_addr, bram_wrdata.
REQ-021 Requests in flight when reset asserts SHALL be discarded; no rsp_valid SHALL appear after reset deasserts.

Configuration
REQ-022 With BRAM_ARB_PERF_EN defined, the block SHALL add three outputs:
- perf_grant0, 32 bits: count of r0 transfers.
- perf_grant1, 32 bits: count of r1 transfers.
- perf_conflict, 32 bits: cycles with both valids high.
- All three SHALL saturate at 0xFFFFFFFF and reset to 0.
REQ-023 Without BRAM_ARB_PERF_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-024 Shared package bram_arb_pkg SHALL hold:
- ADDR_W and DATA_W defaults;
- requester-ID typedef (1 bit);
- request struct (we, addr, wdata);
- response-pipeline entry struct (valid, id).
REQ-025 The 2-way round-robin picker (valids + pointer -> one-hot grant + next pointer) SHALL be sub-module bram_arb_rr.

Verification
REQ-026 Single read: after reset, r0 reads addr 0x010 holding 0xDEADBEEF.
- Response: r0_req_ready in T; bram_en=1 and bram_addr=0x010 in T+1; r0_rsp_valid with 0xDEADBEEF in T+2; r1_rsp_valid stays 0.
REQ-027 Persistent conflict: both requesters hold valid for 6 cycles.
- Response: grants alternate r0,r1,r0,r1,r0,r1; with PERF_EN, perf_conflict=6 and perf_grant0=perf_grant1=3.
REQ-028 Write then read: r1 writes 0x12345678 to 0x7FF with we=0xF at T; r0 reads 0x7FF at T+1.
- Response: r0_rsp_valid with 0x12345678 at T+3; no response for the write.
REQ-029 Byte write: write 0x000000AA with we=0x1 to a word holding 0xFFFFFFFF, then read the word back.
- Response: read data 0xFFFFFFAA.
REQ-030 Reset mid-read: assert reset in T+1 after a read transfers in T; release in T+3.
- Response: no rsp_valid in any cycle; pointer selects r0 on the next conflict.
REQ-031 Counter saturation (PERF_EN): force perf_grant0 to 0xFFFFFFFE, then perform 3 r0 transfers.
- Response: perf_grant0 reads 0xFFFFFFFF.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the bram_port_arbiter slice.
package bram_arb_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;
   localparam int STRB_W_DEF = DATA_W_DEF / 8;

   typedef logic req_id_t;

   typedef struct packed {
      logic [STRB_W_DEF-1:0] we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } bram_req_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rsp_entry_t;
endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin picker: valids plus priority pointer give a one-hot grant and the next pointer.
module bram_arb_rr
   import bram_arb_pkg::*;
(
   input  logic [1:0] req_valid,
   input  req_id_t    ptr,
   output logic [1:0] grant,
   output req_id_t    next_ptr
);

   always_comb begin
      grant    = 2'b00;
      next_ptr = ptr;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
      // The loser of this cycle gets priority next time.
      if (grant[0])
         next_ptr = 1'b1;
      else if (grant[1])
         next_ptr = 1'b0;
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single BRAM port (1-cycle read latency).
// Optional performance counters are enabled with `define BRAM_ARB_PERF_EN.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              r0_req_valid,
   output logic              r0_req_ready,
   input  logic [STRB_W-1:0] r0_req_we,
   input  logic [ADDR_W-1:0] r0_req_addr,
   input  logic [DATA_W-1:0] r0_req_wdata,
   output logic              r0_rsp_valid,
   output logic [DATA_W-1:0] r0_rsp_rdata,
   input  logic              r1_req_valid,
   output logic              r1_req_ready,
   input  logic [STRB_W-1:0] r1_req_we,
   input  logic [ADDR_W-1:0] r1_req_addr,
   input  logic [DATA_W-1:0] r1_req_wdata,
   output logic              r1_rsp_valid,
   output logic [DATA_W-1:0] r1_rsp_rdata,
   output logic              bram_en,
   output logic [STRB_W-1:0] bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wrdata,
   input  logic [DATA_W-1:0] bram_rddata
`ifdef BRAM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_grant0,
   output logic [31:0]       perf_grant1,
   output logic [31:0]       perf_conflict
`endif
);

   req_id_t           ptr_q;
   req_id_t           ptr_nxt;
   logic [1:0]        grant;
   logic [1:0]        grant_eff;
   logic              xfer;
   req_id_t           sel_id;
   logic [STRB_W-1:0] sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   rsp_entry_t        pipe_p1;
   rsp_entry_t        pipe_p2;

   bram_arb_rr u_rr (
      .req_valid ({r1_req_valid, r0_req_valid}),
      .ptr       (ptr_q),
      .grant     (grant),
      .next_ptr  (ptr_nxt)
   );

   assign grant_eff    = grant & {2{~reset}};
   assign r0_req_ready = grant_eff[0];
   assign r1_req_ready = grant_eff[1];
   assign xfer         = |grant_eff;

   assign sel_id    = grant_eff[1];
   assign sel_we    = sel_id ? r1_req_we    : r0_req_we;
   assign sel_addr  = sel_id ? r1_req_addr  : r0_req_addr;
   assign sel_wdata = sel_id ? r1_req_wdata : r0_req_wdata;

   // p1: issue stage toward the BRAM, p2: BRAM read data is present
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q       <= 1'b0;
         bram_en     <= 1'b0;
         bram_we     <= '0;
         bram_addr   <= '0;
         bram_wrdata <= '0;
         pipe_p1     <= '0;
         pipe_p2     <= '0;
      end else begin
         ptr_q         <= ptr_nxt;
         bram_en       <= xfer;
         bram_we       <= xfer ? sel_we : '0;
         if (xfer) begin
            bram_addr   <= sel_addr;
            bram_wrdata <= sel_wdata;
         end
         pipe_p1.valid <= xfer && (sel_we == '0);
         pipe_p1.id    <= sel_id;
         pipe_p2       <= pipe_p1;
      end
   end

   assign r0_rsp_valid = pipe_p2.valid && (pipe_p2.id == 1'b0);
   assign r1_rsp_valid = pipe_p2.valid && (pipe_p2.id == 1'b1);
   assign r0_rsp_rdata = r0_rsp_valid ? bram_rddata : '0;
   assign r1_rsp_rdata = r1_rsp_valid ? bram_rddata : '0;

`ifdef BRAM_ARB_PERF_EN
   logic [31:0] perf_g0_q;
   logic [31:0] perf_g1_q;
   logic [31:0] perf_cf_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_g0_q <= '0;
         perf_g1_q <= '0;
         perf_cf_q <= '0;
      end else begin
         perf_g0_q <= sat_inc(perf_g0_q, grant_eff[0]);
         perf_g1_q <= sat_inc(perf_g1_q, grant_eff[1]);
         perf_cf_q <= sat_inc(perf_cf_q, r0_req_valid & r1_req_valid);
      end
   end

   assign perf_grant0   = perf_g0_q;
   assign perf_grant1   = perf_g1_q;
   assign perf_conflict = perf_cf_q;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: directed scenarios followed by random traffic.
module tb_bram_port_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              r0_req_valid = 1'b0, r1_req_valid = 1'b0;
   logic              r0_req_ready, r1_req_ready;
   logic [STRB_W-1:0] r0_req_we = '0, r1_req_we = '0;
   logic [ADDR_W-1:0] r0_req_addr = '0, r1_req_addr = '0;
   logic [DATA_W-1:0] r0_req_wdata = '0, r1_req_wdata = '0;
   logic              r0_rsp_valid, r1_rsp_valid;
   logic [DATA_W-1:0] r0_rsp_rdata, r1_rsp_rdata;
   logic              bram_en;
   logic [STRB_W-1:0] bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wrdata;
   logic [DATA_W-1:0] bram_rddata = '0;
`ifdef BRAM_ARB_PERF_EN
   logic [31:0]       perf_grant0, perf_grant1, perf_conflict;
`endif

   bram_port_arbiter dut (
      .clock        (clock),
      .reset        (reset),
      .r0_req_valid (r0_req_valid),
      .r0_req_ready (r0_req_ready),
      .r0_req_we    (r0_req_we),
      .r0_req_addr  (r0_req_addr),
      .r0_req_wdata (r0_req_wdata),
      .r0_rsp_valid (r0_rsp_valid),
      .r0_rsp_rdata (r0_rsp_rdata),
      .r1_req_valid (r1_req_valid),
      .r1_req_ready (r1_req_ready),
      .r1_req_we    (r1_req_we),
      .r1_req_addr  (r1_req_addr),
      .r1_req_wdata (r1_req_wdata),
      .r1_rsp_valid (r1_rsp_valid),
      .r1_rsp_rdata (r1_rsp_rdata),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_wrdata  (bram_wrdata),
      .bram_rddata  (bram_rddata)
`ifdef BRAM_ARB_PERF_EN
      ,
      .perf_grant0  (perf_grant0),
      .perf_grant1  (perf_grant1),
      .perf_conflict(perf_conflict)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   function automatic logic [31:0] init_word(input int i);
      if (i == 'h010) return 32'hDEAD_BEEF;
      if (i == 'h020) return 32'hFFFF_FFFF;
      return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   // BRAM behavioural model: 1-cycle registered read, byte-enabled writes
   logic [DATA_W-1:0] mem [0:4095];
   bit                mem_loaded = 0;
   always @(posedge clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
         mem_loaded = 1;
      end
      if (bram_en) begin
         bram_rddata <= mem[bram_addr];
         for (int b = 0; b < STRB_W; b++)
            if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
      end
   end

   // Scoreboard state
   typedef struct {
      bit          id;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [0:4095];
   bit          ref_loaded = 0;
   int          vectors = 0;
   int          errors = 0;
   bit          prio;
   bit          prev_xfer;
   logic [3:0]  prev_we;
   logic [11:0] last_addr;
   logic [31:0] last_wdata;
   int          drain_req = 0, drain_seen = 0;
   int          perf_req = 0, perf_seen = 0;
   logic [31:0] pe_g0 = 0, pe_g1 = 0, pe_cf = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clock) begin
      logic [1:0]  exp_g;
      logic [3:0]  we;
      logic [11:0] addr;
      logic [31:0] wd;
      bit          id;
      exp_t        e;
      if (!ref_loaded) begin
         for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
         ref_loaded = 1;
      end
      if (reset) begin
         chk("rst_ready", {r1_req_ready, r0_req_ready}, 0);
         chk("rst_rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 0);
         chk("rst_rsp_rdata", {r1_rsp_rdata, r0_rsp_rdata}, 0);
         chk("rst_bram", {bram_en, bram_we, bram_addr, bram_wrdata}, 0);
         prio = 0; prev_xfer = 0; prev_we = 0; last_addr = 0; last_wdata = 0;
         exp_q.delete();
      end else begin
         chk("bram_en", bram_en, prev_xfer);
         chk("bram_we", bram_we, prev_xfer ? prev_we : 4'h0);
         chk("bram_addr", bram_addr, last_addr);
         chk("bram_wrdata", bram_wrdata, last_wdata);
         if (r0_rsp_valid || r1_rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", {r1_rsp_valid, r0_rsp_valid}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_who", {r1_rsp_valid, r0_rsp_valid}, e.id ? 2'b10 : 2'b01);
               chk("rsp_data", e.id ? r1_rsp_rdata : r0_rsp_rdata, e.data);
               chk("rsp_idle_data", e.id ? r0_rsp_rdata : r1_rsp_rdata, 0);
               chk("rsp_cycle", cyc, e.due);
            end
         end else begin
            chk("rsp_zero_data", {r1_rsp_rdata, r0_rsp_rdata}, 0);
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
               e = exp_q.pop_front();
               chk("rsp_missing", 0, 1);
            end
         end
         // Arbitration rule: lone requester wins, otherwise alternate starting with r0
         if (r0_req_valid && r1_req_valid) exp_g = prio ? 2'b10 : 2'b01;
         else                              exp_g = {r1_req_valid, r0_req_valid};
         chk("ready", {r1_req_ready, r0_req_ready}, exp_g);
         prev_xfer = |exp_g;
         if (prev_xfer) begin
            id   = exp_g[1];
            we   = id ? r1_req_we : r0_req_we;
            addr = id ? r1_req_addr : r0_req_addr;
            wd   = id ? r1_req_wdata : r0_req_wdata;
            prev_we = we; last_addr = addr; last_wdata = wd;
            prio = ~id;
            if (we == 0) exp_q.push_back('{id: id, data: ref_mem[addr], due: cyc + 2});
            else for (int b = 0; b < 4; b++) if (we[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
         end
      end
`ifdef BRAM_ARB_PERF_EN
      if (perf_req != perf_seen) begin
         chk("perf_grant0", perf_grant0, pe_g0);
         chk("perf_grant1", perf_grant1, pe_g1);
         chk("perf_conflict", perf_conflict, pe_cf);
         perf_seen = perf_req;
      end
`endif
      if (drain_req != drain_seen) begin
         chk("drain_outstanding", exp_q.size(), 0);
         drain_seen = drain_req;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      r0_req_valid = 0;
      r1_req_valid = 0;
   endtask

   task automatic set_req(input bit id, input bit v, input logic [3:0] we,
                          input logic [11:0] a, input logic [31:0] d);
      if (id) begin
         r1_req_valid = v; r1_req_we = we; r1_req_addr = a; r1_req_wdata = d;
      end else begin
         r0_req_valid = v; r0_req_we = we; r0_req_addr = a; r0_req_wdata = d;
      end
   endtask

   task automatic pulse_reset();
      idle();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   initial begin
      reset = 1;
      repeat (3) step();
      reset = 0;
      step();

      // Single read of a known word
      set_req(0, 1, 4'h0, 12'h010, 32'h0);
      step();
      idle();
      repeat (4) step();

      // Persistent conflict from a fresh reset
      pulse_reset();
      set_req(0, 1, 4'h0, 12'h100, 32'h0);
      set_req(1, 1, 4'h0, 12'h200, 32'h0);
      repeat (6) step();
      idle();
      pe_g0 = 3; pe_g1 = 3; pe_cf = 6;
      perf_req++;
      repeat (3) step();

`ifdef BRAM_ARB_PERF_EN
      force dut.perf_g0_q = 32'hFFFF_FFFE;
      step();
      release dut.perf_g0_q;
      for (int i = 0; i < 3; i++) begin
         set_req(0, 1, 4'h0, 12'(i), 32'h0);
         step();
      end
      idle();
      pe_g0 = 32'hFFFF_FFFF;
      perf_req++;
      repeat (3) step();
`endif

      // Write then read of the same word from different requesters
      set_req(1, 1, 4'hF, 12'h7FF, 32'h1234_5678);
      step();
      set_req(1, 0, 4'h0, 12'h0, 32'h0);
      set_req(0, 1, 4'h0, 12'h7FF, 32'h0);
      step();
      idle();
      repeat (4) step();

      // Byte write merges into an all-ones word
      set_req(0, 1, 4'h1, 12'h020, 32'h0000_00AA);
      step();
      set_req(0, 1, 4'h0, 12'h020, 32'h0);
      step();
      idle();
      repeat (4) step();

      // Reset while a read is in flight, then a conflict must favour r0
      set_req(0, 1, 4'h0, 12'h010, 32'h0);
      step();
      idle();
      reset = 1;
      step();
      step();
      reset = 0;
      set_req(0, 1, 4'h0, 12'h030, 32'h0);
      set_req(1, 1, 4'h0, 12'h031, 32'h0);
      repeat (2) step();
      idle();
      repeat (4) step();

      // Random traffic on a small address window to force read-after-write hits
      for (int n = 0; n < 1500; n++) begin
         for (int r = 0; r < 2; r++)
            set_req(r[0], $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                    12'h7F0 + 12'($urandom_range(0, 15)), $urandom);
         step();
      end
      idle();
      repeat (5) step();

      drain_req++;
      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
